// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch stage.
// Contents:
//   PipeWidth / PipeNopInstr - default datapath width and bubble encoding
//   fetch_state_e            - fetch FSM state encoding (StBoot, StFetch, StDiscard)
//   Rs*/Rt*                  - register-specifier field positions inside an instruction word
package pipeline_pkg;

    localparam int unsigned PipeWidth    = 32;
    localparam logic [31:0] PipeNopInstr = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot    = 2'd0,
        StFetch   = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

    localparam int unsigned RsMsb = 25;
    localparam int unsigned RsLsb = 21;
    localparam int unsigned RtMsb = 20;
    localparam int unsigned RtLsb = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous reset, clears the count
//   inc_i   - increment request for this cycle
//   count_o - current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory req/ready handshake
// and the IF/ID pipeline register, with saturating stall/flush counters.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   pc_write_i              - 0 holds the PC (hazard unit stall)
//   if_id_write_i           - 0 holds the IF/ID register
//   redirect_i/_target_i    - branch/jump redirect from ID and its new PC
//   imem_ready_i/_data_i    - instruction memory response
//   imem_req_o/_addr_o      - fetch request and address (stable while waiting)
//   if_id_instr_o/_pc4_o    - registered instruction and its PC+4
//   if_id_valid_o           - IF/ID holds a real fetched instruction
//   if_id_rs/rt_addr_o      - register specifier fields of if_id_instr_o
//   stall_count_o           - cycles with pc_write_i=0, saturating
//   flush_count_o           - accepted redirects, saturating
module if_id_fetch_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned      WIDTH     = PipeWidth,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(PipeNopInstr),
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pc_write_i,
    input  logic             if_id_write_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_target_i,
    input  logic             imem_ready_i,
    input  logic [WIDTH-1:0] imem_data_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    output logic [WIDTH-1:0] if_id_instr_o,
    output logic [WIDTH-1:0] if_id_pc4_o,
    output logic             if_id_valid_o,
    output logic [4:0]       if_id_rs_addr_o,
    output logic [4:0]       if_id_rt_addr_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    // Address of the access still in flight when a redirect arrived mid-wait.
    logic [WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc4_q, pc4_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] pc_plus4;
    logic             accept;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign accept   = (state_q == StFetch) && imem_ready_i && pc_write_i && !redirect_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_addr_d = hold_addr_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;

        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end
            StFetch: begin
                // The memory still owns the current address, so finish it off-path.
                if (redirect_i && !imem_ready_i) begin
                    state_d     = StDiscard;
                    hold_addr_d = pc_q;
                end
            end
            StDiscard: begin
                if (imem_ready_i) begin
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        if (redirect_i) begin
            pc_d = redirect_target_i;
        end else if (accept) begin
            pc_d = pc_plus4;
        end

        // A redirect flushes IF/ID regardless of the hazard unit's write enable.
        if (redirect_i || if_id_write_i) begin
            if (accept) begin
                instr_d = imem_data_i;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            hold_addr_q <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_addr_q <= hold_addr_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
        end
    end

    assign imem_req_o      = (state_q != StBoot);
    assign imem_addr_o     = (state_q == StDiscard) ? hold_addr_q : pc_q;
    assign if_id_instr_o   = instr_q;
    assign if_id_pc4_o     = pc4_q;
    assign if_id_valid_o   = valid_q;
    assign if_id_rs_addr_o = instr_q[RsMsb:RsLsb];
    assign if_id_rt_addr_o = instr_q[RtMsb:RtLsb];

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (!pc_write_i),
        .count_o (stall_count_o)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (redirect_i),
        .count_o (flush_count_o)
    );

endmodule
